memwb_skid_stage: RTL

// - Elastic MEM->WB pipeline stage: 2-entry skid buffer with valid/ready handshake, stall and flush.
// - Registers load data, ALU result, destination register and control bits between the MEM and WB stages.
// - Also produces the final writeback value and a write enable gated by valid, with x0 suppressed.
// - Lets a stalled WB (e.g. a register-file port conflict) back-pressure MEM without dropping an instruction.

---
 rtl/memwb_skid_stage.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/memwb_skid_stage.sv
// memwb_skid_stage: elastic MEM->WB pipeline register built as a 2-entry skid
// buffer (head + skid) with valid/ready handshake, stall and flush. Also forms
// the final writeback value and a valid-gated, x0-suppressed write enable.
// Optional build macro: MEMWB_PERF_EN adds stall/bubble performance counters.
//
// state | meaning
// EMPTY | head invalid, skid invalid
// ONE   | head valid,   skid invalid
// FULL  | head valid,   skid valid (skid younger than head), in_ready low
module memwb_skid_stage #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               RegWrite,
  input  logic               MemtoReg,
  input  logic [XLEN-1:0]    Read_data,
  input  logic [XLEN-1:0]    ALU_result,
  input  logic [RADDR_W-1:0] Register_dest,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               RegWrite_out,
  output logic               MemtoReg_out,
  output logic [XLEN-1:0]    Read_data_out,
  output logic [XLEN-1:0]    ALU_result_out,
  output logic [RADDR_W-1:0] Register_dest_out,
  output logic [XLEN-1:0]    wb_data
`ifdef MEMWB_PERF_EN
  ,
  output logic [31:0]        perf_stall_cnt,
  output logic [31:0]        perf_bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic               reg_write;
    logic               mem_to_reg;
    logic [XLEN-1:0]    read_data;
    logic [XLEN-1:0]    alu_result;
    logic [RADDR_W-1:0] rd;
  } entry_t;

  state_t state_q, state_d;
  entry_t head_q, head_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;
  logic   accept;
  logic   pop;

  // Valids live in the state encoding; in_ready comes straight from the state register.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;

  assign in_entry = '{reg_write:  RegWrite,
                      mem_to_reg: MemtoReg,
                      read_data:  Read_data,
                      alu_result: ALU_result,
                      rd:         Register_dest};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and entry-move decisions; flush wins over any accept.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          head_d  = in_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && pop) begin
          head_d = in_entry;
        end else if (accept) begin
          skid_d  = in_entry;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          head_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
    end
  end

  // Entry payload registers; cleared on reset so outputs read zero afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      skid_q <= '0;
    end else begin
      head_q <= head_d;
      skid_q <= skid_d;
    end
  end

  assign MemtoReg_out      = head_q.mem_to_reg;
  assign Read_data_out     = head_q.read_data;
  assign ALU_result_out    = head_q.alu_result;
  assign Register_dest_out = head_q.rd;
  assign RegWrite_out      = head_q.reg_write & out_valid & (|head_q.rd);
  assign wb_data           = head_q.mem_to_reg ? head_q.read_data : head_q.alu_result;

`ifdef MEMWB_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_bubble_q;

  // Stall/bubble counters; they survive flush and wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_q  <= '0;
      perf_bubble_q <= '0;
    end else begin
      if (out_valid && !out_ready) perf_stall_q <= perf_stall_q + 32'd1;
      if (!out_valid)              perf_bubble_q <= perf_bubble_q + 32'd1;
    end
  end

  assign perf_stall_cnt  = perf_stall_q;
  assign perf_bubble_cnt = perf_bubble_q;
`endif

endmodule
